// File: rtl/mc_pkg.sv
// Shared definitions for the mini computer timing front end:
// stepper states, phase encodings and the width of the step vector.
package mc_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    SINGLE
  } state_t;

  localparam logic [1:0] PH_EN0 = 2'd0;
  localparam logic [1:0] PH_SET = 2'd1;
  localparam logic [1:0] PH_EN1 = 2'd2;
  localparam logic [1:0] PH_GAP = 2'd3;

  localparam int STEP_W = 7;

endpackage

// File: rtl/step_ring.sv
// One-hot instruction step register. Rotates left on adv and wraps from
// bit NSTEPS-1 back to bit 0, flagging the wrap so the caller can count it.
module step_ring
  import mc_pkg::*;
#(
  parameter int NSTEPS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [STEP_W-1:0] step,
  output logic              wrap
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    wrap   = adv & step_q[NSTEPS-1];
    step_d = step_q;
    if (adv) begin
      step_d = wrap ? STEP_W'(1) : (step_q << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q <= STEP_W'(1);
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/clock_stepper.sv
// Timing front end: four-phase strobe generation, one-hot step sequencing,
// halt / resume / single-step control and a completed-instruction counter.
module clock_stepper
  import mc_pkg::*;
#(
  parameter int NSTEPS = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              resume,
  input  logic              single,
  output logic              clk_en,
  output logic              clk_set,
  output logic [STEP_W-1:0] step,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       ph_q;
  logic [1:0]       ph_d;
  logic             halt_pend_q;
  logic             halt_pend_d;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] instr_cnt_d;
  logic             adv;
  logic             wrap;
  logic             step_end;
  logic             active;

  step_ring #(
    .NSTEPS(NSTEPS)
  ) u_step_ring (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .step(step),
    .wrap(wrap)
  );

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    halt_pend_d = halt_pend_q;
    adv         = 1'b0;
    step_end    = (ph_q == PH_GAP);

    unique case (state_q)
      RUN: begin
        ph_d = ph_q + 2'd1;
        if (halt) begin
          halt_pend_d = 1'b1;
        end
        // A halt seen anywhere in the step lets that step finish first.
        if (step_end) begin
          adv = 1'b1;
          if (halt_pend_q || halt) begin
            state_d     = HALTED;
            halt_pend_d = 1'b0;
          end
        end
      end
      SINGLE: begin
        ph_d = ph_q + 2'd1;
        if (step_end) begin
          adv     = 1'b1;
          state_d = HALTED;
        end
      end
      HALTED: begin
        ph_d = PH_EN0;
        if (resume) begin
          state_d = RUN;
        end else if (single) begin
          state_d = SINGLE;
        end
      end
      default: begin
        state_d = RUN;
        ph_d    = PH_EN0;
      end
    endcase

    instr_cnt_d = wrap ? (instr_cnt_q + CNT_W'(1)) : instr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      ph_q        <= PH_EN0;
      halt_pend_q <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      halt_pend_q <= halt_pend_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Strobes are gated by rst so they drop in the very cycle reset is applied.
  assign active    = rst && ((state_q == RUN) || (state_q == SINGLE));
  assign clk_en    = active && (ph_q != PH_GAP);
  assign clk_set   = active && (ph_q == PH_SET);
  assign halted    = rst && (state_q == HALTED);
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_clock_stepper.sv
// Randomized bench for clock_stepper: two instances (6 steps / 16-bit count
// and 3 steps / 4-bit count) checked every cycle against a step-index model.
module tb_clock_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt;
  logic       resume;
  logic       single;

  logic       clkEn6, clkSet6, halted6;
  logic [6:0] step6;
  logic [15:0] instrCnt6;
  logic       clkEn3, clkSet3, halted3;
  logic [6:0] step3;
  logic [3:0] instrCnt3;

  int checks   = 0;
  int failures = 0;
  int setCount = 0;
  int haltCount = 0;

  // mode: 0 = running, 1 = halted, 2 = single step
  typedef struct {
    int ph;
    int idx;
    int cnt;
    int mode;
    bit pend;
  } model_t;

  model_t m6;
  model_t m3;

  always #5 clk = ~clk;

  clock_stepper #(.NSTEPS(6), .CNT_W(16)) dut6 (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .resume   (resume),
    .single   (single),
    .clk_en   (clkEn6),
    .clk_set  (clkSet6),
    .step     (step6),
    .halted   (halted6),
    .instr_cnt(instrCnt6)
  );

  clock_stepper #(.NSTEPS(3), .CNT_W(4)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .resume   (resume),
    .single   (single),
    .clk_en   (clkEn3),
    .clk_set  (clkSet3),
    .step     (step3),
    .halted   (halted3),
    .instr_cnt(instrCnt3)
  );

  function automatic model_t resetModel();
    model_t m;
    m.ph = 0; m.idx = 0; m.cnt = 0; m.mode = 0; m.pend = 1'b0;
    return m;
  endfunction

  // Behaviour at one clock edge, in terms of step index and phase number.
  function automatic model_t modelNext(model_t m, bit r, bit h, bit res, bit sg,
                                       int nsteps, int cntMod);
    model_t n;
    bit endStep;
    n = m;
    endStep = 1'b0;
    if (!r) return resetModel();
    if (m.mode == 0) begin
      if (h) n.pend = 1'b1;
      n.ph = (m.ph + 1) % 4;
      if (m.ph == 3) begin
        endStep = 1'b1;
        if (m.pend || h) begin
          n.mode = 1;
          n.pend = 1'b0;
        end
      end
    end else if (m.mode == 2) begin
      n.ph = (m.ph + 1) % 4;
      if (m.ph == 3) begin
        endStep = 1'b1;
        n.mode = 1;
      end
    end else begin
      n.ph = 0;
      if (res) n.mode = 0;
      else if (sg) n.mode = 2;
    end
    if (endStep) begin
      if (m.idx == nsteps - 1) begin
        n.idx = 0;
        n.cnt = (m.cnt + 1) % cntMod;
      end else begin
        n.idx = m.idx + 1;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    bit a6, a3;
    a6 = (m6.mode != 1) && rst;
    a3 = (m3.mode != 1) && rst;
    checkOutput("en6",     32'(clkEn6),    32'(a6 && (m6.ph != 3)));
    checkOutput("set6",    32'(clkSet6),   32'(a6 && (m6.ph == 1)));
    checkOutput("step6",   32'(step6),     32'(1) << m6.idx);
    checkOutput("halted6", 32'(halted6),   32'(rst && (m6.mode == 1)));
    checkOutput("cnt6",    32'(instrCnt6), 32'(m6.cnt));
    checkOutput("en3",     32'(clkEn3),    32'(a3 && (m3.ph != 3)));
    checkOutput("set3",    32'(clkSet3),   32'(a3 && (m3.ph == 1)));
    checkOutput("step3",   32'(step3),     32'(1) << m3.idx);
    checkOutput("halted3", 32'(halted3),   32'(rst && (m3.mode == 1)));
    checkOutput("cnt3",    32'(instrCnt3), 32'(m3.cnt));
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input bit r, input bit h, input bit res, input bit sg);
    rst = r; halt = h; resume = res; single = sg;
    #1;
    checkAll();
    if (clkSet6) setCount++;
    if (halted6) haltCount++;
    @(posedge clk);
    m6 = modelNext(m6, r, h, res, sg, 6, 65536);
    m3 = modelNext(m3, r, h, res, sg, 3, 16);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int guard;
    rst = 1'b0; halt = 1'b0; resume = 1'b0; single = 1'b0;
    repeat (2) @(posedge clk);
    m6 = resetModel();
    m3 = resetModel();
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);

    for (int c = 0; c < 192; c++) begin
      applyStimulus(1, 0, 0, 0);
      if (c == 47) begin
        checkOutput("freerun_cnt48", 32'(instrCnt6), 32'd2);
        checkOutput("freerun_step48", 32'(step6), 32'h01);
      end
      if (c == 179) checkOutput("cnt4_at15", 32'(instrCnt3), 32'd15);
      if (c == 191) checkOutput("cnt4_wrap", 32'(instrCnt3), 32'd0);
    end

    applyStimulus(0, 0, 0, 0);
    for (int c = 0; c < 20; c++) applyStimulus(1, (c == 17), 0, 0);
    checkOutput("halt_en", 32'(clkEn6), 32'd0);
    checkOutput("halt_flag", 32'(halted6), 32'd1);
    checkOutput("halt_step", 32'(step6), 32'h20);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("halt_hold", 32'(step6), 32'h20);

    setCount = 0;
    applyStimulus(1, 0, 0, 1);
    repeat (4) applyStimulus(1, 0, 0, 0);
    checkOutput("single_sets", 32'(setCount), 32'd1);
    checkOutput("single_step", 32'(step6), 32'h01);
    checkOutput("single_cnt", 32'(instrCnt6), 32'd1);
    checkOutput("single_halted", 32'(halted6), 32'd1);

    applyStimulus(1, 0, 1, 1);
    haltCount = 0;
    repeat (40) applyStimulus(1, 0, 0, 0);
    checkOutput("resume_wins", 32'(haltCount), 32'd0);

    guard = 0;
    while (!(m6.idx == 2 && m6.ph == 2) && guard < 100) begin
      applyStimulus(1, 0, 0, 0);
      guard++;
    end
    checkOutput("reach_s2p2", 32'(guard < 100), 32'd1);
    applyStimulus(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("rst_step", 32'(step6), 32'h01);
    checkOutput("rst_cnt", 32'(instrCnt6), 32'd0);
    checkOutput("rst_en", 32'(clkEn6), 32'd1);
    checkOutput("rst_set", 32'(clkSet6), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_stepper.md
# clock_stepper

Timing front end of the mini computer. It derives the enable-phase strobe (`clk_en`) and the set-phase strobe (`clk_set`) from the single system clock. It sequences the one-hot instruction step vector consumed by `control_section`. It also owns halt, resume and single-step control, so `control_section` no longer contains its own step wrap logic.

## Interface
Parameters:
- `NSTEPS`, default 6: number of active steps per instruction. Legal range 2–7.
- `CNT_W`, default 16: width of the completed-instruction counter.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous, active-low.
- `halt`, in, 1: halt request from control (HLT decode). Level, sampled every cycle.
- `resume`, in, 1: one-cycle pulse. Leave the halted state and run freely.
- `single`, in, 1: one-cycle pulse. While halted, execute exactly one step.
- `clk_en`, out, 1: enable-phase strobe (bus drive window).
- `clk_set`, out, 1: set-phase strobe (register capture).
- `step`, out, 7: one-hot step. Bits at index `NSTEPS` and above are always 0.
- `halted`, out, 1: high while in HALTED.
- `instr_cnt`, out, `CNT_W`: count of completed instructions.

## Operation
- Each step occupies 4 clock cycles. A 2-bit phase counter `ph` runs 0 → 1 → 2 → 3 → 0.
- Strobes are decoded combinationally from registered state:
  - `clk_en` = active & (`ph` != 3)
  - `clk_set` = active & (`ph` == 1)
  - "active" means state is RUN or SINGLE and `rst` is high.
- The set window is nested inside the enable window.
- Step advance happens only at the end of `ph`==3 while active. `step` rotates left by one. From bit `NSTEPS-1` it wraps to bit 0 and `instr_cnt` increments, wrapping modulo 2^`CNT_W`.
- States:
  - RUN: phases advance every cycle.
  - HALTED: `ph` is held at 0, `step` is held, strobes are 0.
  - SINGLE: runs exactly one step (4 cycles), then goes to HALTED.
- `halt_pend` flag:
  - Set when `halt`=1 in RUN in any phase.
  - At the end of `ph`==3 with `halt_pend`=1 (or with `halt`=1 in that same cycle): the step advances normally, the state becomes HALTED, and `halt_pend` clears.
- Transitions out of HALTED:
  - `resume`=1 → RUN.
  - Else `single`=1 → SINGLE.
  - Both asserted in the same cycle: `resume` wins.
- Ignored inputs:
  - `halt` while HALTED or SINGLE.
  - `resume` and `single` while RUN or SINGLE.

## Timing
- Reset values (while `rst`=0): `ph`=0, `step`=0000001, state RUN, `halt_pend`=0, `instr_cnt`=0, `halted`=0, `clk_en`=0, `clk_set`=0.
- Reset applied mid-step aborts the step immediately. There is no completion of the current phase sequence.
- First cycle after `rst` rises: `ph`=0, `step[0]`=1, `clk_en`=1, `clk_set`=0.
- `clk_set` is high exactly 1 of every 4 active cycles. `clk_en` is high 3 of 4.
- Free-run instruction length is 4·`NSTEPS` cycles (24 at the default).
- Halt latency: strobes drop to 0 in the cycle after the `ph`==3 that ends the step in which `halt` was seen. `halted` rises in that same cycle.
- Resume latency: in the cycle after the `resume` pulse, `ph`=0 and `clk_en`=1 on the held step.
- `instr_cnt` updates in the cycle after the wrap, together with the `step[0]` assertion.

## Structure
- Shared package `mc_pkg`:
  - State enum {RUN, HALTED, SINGLE}.
  - Phase constants PH_EN0=0, PH_SET=1, PH_EN1=2, PH_GAP=3.
  - `STEP_W`=7.
- Sub-module `step_ring`: one-hot rotate register with `adv`, wrap at `NSTEPS-1`, synchronous active-low reset to bit 0, and a `wrap` output that drives the `instr_cnt` increment.
- The top level holds the phase counter, the state machine, the halt flag and the counter.

## Test plan
- Reset release, free run 48 cycles: `clk_en` pattern 1110 repeating; `clk_set` high on cycles 1, 5, 9, …; `step` walks 0000001 → 0100000 → 0000001; `instr_cnt`=2 at cycle 48.
- `halt` pulsed at `step[4]`, `ph`=1: strobes 0 from the cycle after `step[4]` `ph`=3; `step`=0100000 held; `halted`=1.
- From halted at `step[5]`, pulse `single`: exactly one `clk_set`; `step` wraps to 0000001; `instr_cnt` +1; `halted` back to 1 after 4 cycles.
- `resume` and `single` in the same cycle while halted: free run resumes with no return to HALTED; ongoing 1110 pattern.
- `rst` low at `step[2]`, `ph`=2, for 1 cycle: next cycle `step`=0000001, `ph`=0, `instr_cnt`=0, `clk_en`=1.
- `CNT_W`=4, run 16 instructions: `instr_cnt` wraps 15 → 0.
